// File: rtl/score_seg_scan.sv
// rtl/score_seg_scan.sv - time-multiplexed 7-segment scanner for the packed BCD score
// Shadows the score once per frame and drives one common-anode digit at a time.
module score_seg_scan #(
    parameter int DIGIT_TICKS = 100000,
    parameter int NUM_DIGITS  = 4
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic [31:0] bcd,
    input  logic        en,
    input  logic        blank_lz,
    output logic [7:0]  an_n,
    output logic [7:0]  seg_n,
    output logic        frame_start
);

    localparam int TICK_W = (DIGIT_TICKS > 2) ? $clog2(DIGIT_TICKS) : 1;
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(DIGIT_TICKS - 1);
    localparam logic [2:0]        IDX_LAST  = 3'(NUM_DIGITS - 1);

    logic [TICK_W-1:0] tick_q, tick_d;
    logic [2:0]        idx_q, idx_d;
    logic [31:0]       shadow_q, shadow_d;
    logic [7:0]        an_n_q, an_n_d;
    logic [7:0]        seg_n_q, seg_n_d;
    logic              frame_start_q, frame_start_d;

    logic              tick_wrap;
    logic              frame_load;
    logic [7:0]        blank_vec;
    logic              zero_run;
    logic              blanked;
    logic [3:0]        cur_nibble;

    function automatic logic [7:0] seg_decode(input logic [3:0] nib);
        logic [7:0] s;
        case (nib)
            4'd0:    s = 8'hC0;
            4'd1:    s = 8'hF9;
            4'd2:    s = 8'hA4;
            4'd3:    s = 8'hB0;
            4'd4:    s = 8'h99;
            4'd5:    s = 8'h92;
            4'd6:    s = 8'h82;
            4'd7:    s = 8'hF8;
            4'd8:    s = 8'h80;
            4'd9:    s = 8'h90;
            default: s = 8'hBF;
        endcase
        return s;
    endfunction

    assign tick_wrap  = (tick_q == TICK_LAST);
    // With a single digit idx is always at its last value, so every tick wrap reloads.
    assign frame_load = tick_wrap && (idx_q == IDX_LAST);

    always_comb begin
        tick_d        = tick_wrap ? '0 : tick_q + 1'b1;
        idx_d         = idx_q;
        shadow_d      = shadow_q;
        frame_start_d = frame_load;
        if (tick_wrap) begin
            idx_d = (idx_q == IDX_LAST) ? 3'd0 : idx_q + 3'd1;
        end
        if (frame_load) begin
            shadow_d = bcd;
        end
    end

    // A digit is blanked when it and every digit above it (within the scanned range) is zero.
    always_comb begin
        blank_vec = '0;
        zero_run  = 1'b1;
        for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
            zero_run     = zero_run & (shadow_q[4*i +: 4] == 4'd0);
            blank_vec[i] = zero_run & blank_lz;
        end
    end

    assign blanked    = blank_vec[idx_q];
    assign cur_nibble = shadow_q[4*idx_q +: 4];

    always_comb begin
        an_n_d  = 8'hFF;
        seg_n_d = 8'hFF;
        if (!blanked) begin
            seg_n_d = seg_decode(cur_nibble);
            if (en) begin
                an_n_d[idx_q] = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rstn) begin
            tick_q        <= '0;
            idx_q         <= 3'd0;
            shadow_q      <= 32'd0;
            an_n_q        <= 8'hFF;
            seg_n_q       <= 8'hFF;
            frame_start_q <= 1'b0;
        end else begin
            tick_q        <= tick_d;
            idx_q         <= idx_d;
            shadow_q      <= shadow_d;
            an_n_q        <= an_n_d;
            seg_n_q       <= seg_n_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign an_n        = an_n_q;
    assign seg_n       = seg_n_q;
    assign frame_start = frame_start_q;

endmodule

// File: tb/tb_score_seg_scan.sv
// tb/tb_score_seg_scan.sv - directed self-checking bench for score_seg_scan
// Runs with DIGIT_TICKS=4, NUM_DIGITS=4; each digit is lit for 4 clocks.
module tb_score_seg_scan;

    logic        clk;
    logic        rstn;
    logic [31:0] bcd;
    logic        en;
    logic        blank_lz;
    logic [7:0]  an_n;
    logic [7:0]  seg_n;
    logic        frame_start;

    int n_tests;
    int n_fail;

    score_seg_scan #(
        .DIGIT_TICKS(4),
        .NUM_DIGITS (4)
    ) dut (
        .clk        (clk),
        .rstn       (rstn),
        .bcd        (bcd),
        .en         (en),
        .blank_lz   (blank_lz),
        .an_n       (an_n),
        .seg_n      (seg_n),
        .frame_start(frame_start)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Advance to the negedge where frame_start is high (cycle after the shadow load).
    task automatic wait_frame(input string tag);
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (frame_start === 1'b1) break;
        end
        check_val({tag, "_frame_start"}, {31'd0, frame_start}, 32'd1);
    endtask

    // Called at the frame_start negedge; digit k is visible at offsets 1+4k. Ends at offset 13.
    task automatic check_frame(input string tag, input logic [3:0][7:0] exp_an,
                               input logic [3:0][7:0] exp_seg, input logic chk_seg,
                               input logic do_change, input logic [31:0] new_bcd);
        for (int d = 0; d < 4; d++) begin
            step(d == 0 ? 1 : 4);
            if (d == 0) check_val({tag, "_fs_pulse"}, {31'd0, frame_start}, 32'd0);
            check_val($sformatf("%s_an%0d", tag, d), {24'd0, an_n}, {24'd0, exp_an[d]});
            if (chk_seg)
                check_val($sformatf("%s_seg%0d", tag, d), {24'd0, seg_n}, {24'd0, exp_seg[d]});
            if (d == 0 && do_change) bcd = new_bcd;
        end
    endtask

    initial begin
        n_tests  = 0;
        n_fail   = 0;
        rstn     = 1'b1;
        bcd      = 32'h0000_1234;
        en       = 1'b1;
        blank_lz = 1'b1;

        // T1: reset held 3 cycles, then first frame shows a lone 0
        step(3);
        check_val("rst_an", {24'd0, an_n}, 32'hFF);
        check_val("rst_seg", {24'd0, seg_n}, 32'hFF);
        check_val("rst_fs", {31'd0, frame_start}, 32'd0);
        rstn = 1'b0;
        step(1);
        check_val("first_an0", {24'd0, an_n}, 32'hFE);
        check_val("first_seg0", {24'd0, seg_n}, 32'hC0);
        step(4);
        check_val("first_an1", {24'd0, an_n}, 32'hFF);
        check_val("first_seg1", {24'd0, seg_n}, 32'hFF);
        check_val("first_fs", {31'd0, frame_start}, 32'd0);

        // T2: steady scan of 1234 without blanking
        blank_lz = 1'b0;
        wait_frame("t2");
        check_frame("t2", {8'hF7, 8'hFB, 8'hFD, 8'hFE}, {8'hF9, 8'hA4, 8'hB0, 8'h99},
                    1'b1, 1'b0, 32'd0);

        // T3: 0050 with leading-zero blanking, interior and LSD zero kept
        bcd      = 32'h0000_0050;
        blank_lz = 1'b1;
        wait_frame("t3");
        check_frame("t3", {8'hFF, 8'hFF, 8'hFD, 8'hFE}, {8'hFF, 8'hFF, 8'h92, 8'hC0},
                    1'b1, 1'b0, 32'd0);

        // T4: bcd changes mid-frame; the frame keeps showing the snapshot
        bcd      = 32'h0000_1234;
        blank_lz = 1'b0;
        wait_frame("t4a");
        check_frame("t4a", {8'hF7, 8'hFB, 8'hFD, 8'hFE}, {8'hF9, 8'hA4, 8'hB0, 8'h99},
                    1'b1, 1'b1, 32'h0000_5678);
        wait_frame("t4b");
        check_frame("t4b", {8'hF7, 8'hFB, 8'hFD, 8'hFE}, {8'h92, 8'h82, 8'hF8, 8'h80},
                    1'b1, 1'b0, 32'd0);

        // T5: display disabled for a frame, then a dash for the invalid nibble
        bcd      = 32'h0000_00A0;
        blank_lz = 1'b1;
        en       = 1'b0;
        wait_frame("t5a");
        check_frame("t5a", {8'hFF, 8'hFF, 8'hFF, 8'hFF}, {8'hFF, 8'hFF, 8'hFF, 8'hFF},
                    1'b0, 1'b0, 32'd0);
        en = 1'b1;
        wait_frame("t5b");
        check_frame("t5b", {8'hFF, 8'hFF, 8'hFD, 8'hFE}, {8'hFF, 8'hFF, 8'hBF, 8'hC0},
                    1'b1, 1'b0, 32'd0);

        // T6: reset while digit 2 is being scanned clears idx and shadow
        wait_frame("t6");
        step(9);
        rstn = 1'b1;
        step(1);
        check_val("t6_rst_an", {24'd0, an_n}, 32'hFF);
        check_val("t6_rst_seg", {24'd0, seg_n}, 32'hFF);
        check_val("t6_rst_fs", {31'd0, frame_start}, 32'd0);
        rstn = 1'b0;
        step(1);
        check_val("t6_an0", {24'd0, an_n}, 32'hFE);
        check_val("t6_seg0", {24'd0, seg_n}, 32'hC0);
        step(4);
        check_val("t6_an1", {24'd0, an_n}, 32'hFF);
        check_val("t6_seg1", {24'd0, seg_n}, 32'hFF);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
